// File: rtl/adc_scan_reader.sv
// adc_scan_reader
// Scans the enabled ADC channels in ascending order (wrapping) and reads one
// conversion per SPI frame from a serial ADC. A frame is a start bit, a
// single-ended bit and the channel number on mosi. LEAD_BITS idle periods
// follow, and then DATA_BITS result bits are read MSB-first from in_adc.
//
// Ports
//   clk_adc      system clock, every register is on its rising edge
//   rst          synchronous active-high reset
//   enable       scan enable, looked at only when choosing the next channel
//   ch_mask      channels included in the scan, looked at only when choosing
//   chip_select  ADC chip select, active low
//   sclk         ADC serial clock, idle low
//   mosi         command bit to the ADC, changes only while sclk is low
//   in_adc       serial data from the ADC, sampled as sclk is driven high
//   out_valid    result handshake, see the note below
//   out_ready
//   out_channel  channel of the held result
//   datos_adc    value of the held result
//   busy         high while chip_select is low or the chip-select gap runs
//   dbg_state    current FSM state, for observation only
//
// Result handshake: a transfer happens on a clk_adc edge where out_valid and
// out_ready are both high. Once out_valid is raised it stays high, and
// out_channel and datos_adc stay unchanged, until that transfer. out_valid
// drops in the cycle after the transfer. No new frame starts while a result
// is held, so a result can never be overwritten.
module adc_scan_reader #(
   parameter int DATA_BITS = 12,
   parameter int NUM_CH    = 4,
   parameter int LEAD_BITS = 2,
   parameter int SCLK_DIV  = 2,
   parameter int CS_IDLE   = 3,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk_adc,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [NUM_CH-1:0]    ch_mask,
   output logic                 chip_select,
   output logic                 sclk,
   output logic                 mosi,
   input  logic                 in_adc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CH_W-1:0]      out_channel,
   output logic [DATA_BITS-1:0] datos_adc,
   output logic                 busy,
   output logic [2:0]           dbg_state
);

   localparam int CMD_BITS   = 2 + CH_W;
   // The CMD state also covers the lead periods that follow the command.
   localparam int FRONT      = CMD_BITS + LEAD_BITS;
   localparam int GAP_HALVES = 2 * CS_IDLE;
   localparam int MAX_A      = (FRONT > DATA_BITS) ? FRONT : DATA_BITS;
   localparam int CNT_MAX    = (MAX_A > GAP_HALVES) ? MAX_A : GAP_HALVES;
   localparam int BIT_W      = $clog2(CNT_MAX + 1);
   localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [CH_W:0] NUM_CH_W = (CH_W + 1)'(NUM_CH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      CMD    = 3'd2,
      SAMPLE = 3'd3,
      GAP    = 3'd4,
      HOLD   = 3'd5
   } state_t;

   state_t               state, state_next;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 sclk_q;
   logic [CMD_BITS-1:0]  cmd_sh;
   logic [DATA_BITS-1:0] shift_reg;
   logic [CH_W-1:0]      ptr;
   logic [CH_W-1:0]      channel;
   logic [CH_W-1:0]      sel_ch;
   logic [CH_W:0]        idx_w;
   logic                 tick;
   logic                 last_front, last_data, last_gap;
   logic                 start_ok;

   // tick marks the last clk_adc cycle of an sclk half-period.
   assign tick       = (div_cnt == DIV_W'(SCLK_DIV - 1));
   assign last_front = (bit_cnt == BIT_W'(FRONT - 1));
   assign last_data  = (bit_cnt == BIT_W'(DATA_BITS - 1));
   assign last_gap   = (bit_cnt == BIT_W'(GAP_HALVES - 1));
   assign start_ok   = enable && (ch_mask != '0);
   assign dbg_state  = state;

   // Lowest offset from ptr whose mask bit is set wins. The loop runs from
   // the largest offset down, so the last match written is the nearest one.
   always_comb begin
      sel_ch = '0;
      idx_w  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx_w = {1'b0, ptr} + (CH_W + 1)'(i);
         if (idx_w >= NUM_CH_W) idx_w = idx_w - NUM_CH_W;
         if (ch_mask[idx_w[CH_W-1:0]]) sel_ch = idx_w[CH_W-1:0];
      end
   end

   always_ff @(posedge clk_adc) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_ok) state_next = SELECT;
         SELECT:  if (tick) state_next = CMD;
         CMD:     if (tick && sclk_q && last_front) state_next = SAMPLE;
         SAMPLE:  if (tick && sclk_q && last_data) state_next = GAP;
         GAP:     if (tick && last_gap) state_next = HOLD;
         HOLD:    if (!out_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      chip_select = 1'b1;
      busy        = 1'b0;
      mosi        = 1'b0;
      sclk        = 1'b0;
      case (state)
         SELECT: begin
            chip_select = 1'b0;
            busy        = 1'b1;
            mosi        = cmd_sh[CMD_BITS-1];
         end
         CMD: begin
            chip_select = 1'b0;
            busy        = 1'b1;
            mosi        = cmd_sh[CMD_BITS-1];
            sclk        = sclk_q;
         end
         SAMPLE: begin
            chip_select = 1'b0;
            busy        = 1'b1;
            sclk        = sclk_q;
         end
         GAP:     busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_adc) begin
      if (rst) begin
         div_cnt     <= '0;
         bit_cnt     <= '0;
         sclk_q      <= 1'b0;
         cmd_sh      <= '0;
         shift_reg   <= '0;
         ptr         <= '0;
         channel     <= '0;
         out_valid   <= 1'b0;
         out_channel <= '0;
         datos_adc   <= '0;
      end else begin
         if (state == SELECT || state == CMD || state == SAMPLE || state == GAP)
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         else
            div_cnt <= '0;

         if (out_valid && out_ready) out_valid <= 1'b0;

         case (state)
            IDLE: begin
               bit_cnt <= '0;
               sclk_q  <= 1'b0;
               if (start_ok) begin
                  channel <= sel_ch;
                  cmd_sh  <= {2'b11, sel_ch};
               end
            end
            SELECT: if (tick) sclk_q <= 1'b1;
            CMD: if (tick) begin
               if (sclk_q) begin
                  // Falling edge: advance to the next command bit. Zeros
                  // shift in, which gives mosi=0 during the lead periods.
                  sclk_q  <= 1'b0;
                  cmd_sh  <= cmd_sh << 1;
                  bit_cnt <= last_front ? '0 : bit_cnt + BIT_W'(1);
               end else begin
                  sclk_q <= 1'b1;
               end
            end
            SAMPLE: if (tick) begin
               if (!sclk_q) begin
                  sclk_q    <= 1'b1;
                  shift_reg <= DATA_BITS'({shift_reg, in_adc});
               end else begin
                  sclk_q <= 1'b0;
                  if (last_data) begin
                     bit_cnt     <= '0;
                     datos_adc   <= shift_reg;
                     out_channel <= channel;
                     out_valid   <= 1'b1;
                     ptr         <= (channel == CH_W'(NUM_CH - 1)) ? '0 : channel + CH_W'(1);
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end
            GAP: if (tick) bit_cnt <= last_gap ? '0 : bit_cnt + BIT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_scan_reader.sv
// Bench for adc_scan_reader with default parameters. A behavioural ADC
// decodes the command from mosi and returns a per-channel value. A scoreboard
// queue holds the expected {channel, data} results, in the order the scan
// must produce them.
module tb_adc_scan_reader;

   logic        clk_adc = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [3:0]  ch_mask = 4'b0000;
   logic        chip_select, sclk, mosi;
   logic        in_adc = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  out_channel;
   logic [11:0] datos_adc;
   logic        busy;
   logic [2:0]  dbg_state;

   adc_scan_reader dut (
      .clk_adc(clk_adc), .rst(rst), .enable(enable), .ch_mask(ch_mask),
      .chip_select(chip_select), .sclk(sclk), .mosi(mosi), .in_adc(in_adc),
      .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
      .datos_adc(datos_adc), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk_adc = ~clk_adc;

   int n_checks = 0;
   int n_pass   = 0;
   logic [13:0] exp_q[$];
   logic [11:0] ch_val [4];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endfunction

   // out_ready driver: either a fixed level or random back-pressure.
   logic rand_ready  = 1'b0;
   logic ready_level = 1'b1;
   initial forever begin
      @(posedge clk_adc);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
   end

   // ADC model, scoreboard and protocol monitor, sampled on the falling edge.
   int          rise_cnt = 0, frame_len = 0, hi_run = 0, viol = 0;
   logic [3:0]  cmd_bits = 4'b0;
   logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
   logic        had_frame = 1'b0, frame_abort = 1'b1;
   logic        prev_valid = 1'b0, prev_fire = 1'b0, prev_rst = 1'b1;
   logic [1:0]  prev_ch = 2'b0;
   logic [11:0] prev_data = 12'b0;
   logic        fire;
   logic [13:0] exp_e;
   logic [11:0] cur_val;

   initial forever begin
      @(negedge clk_adc);
      fire = out_valid && out_ready && !rst;
      if (fire) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got ch %0d data 0x%0h, required no result", out_channel, datos_adc);
         end else begin
            exp_e = exp_q.pop_front();
            check("result", 32'({out_channel, datos_adc}), 32'(exp_e));
         end
      end
      if (prev_valid && !prev_fire && !prev_rst)
         check("hold_stable", 32'({out_valid, out_channel, datos_adc}), 32'({1'b1, prev_ch, prev_data}));
      if (chip_select && sclk) viol++;
      if (mosi !== prev_mosi && sclk) viol++;
      if (rst) begin
         frame_abort = 1'b1;
         had_frame   = 1'b0;
      end
      if (!chip_select && prev_cs) begin
         if (had_frame) check("cs_gap_ge_12", 32'(hi_run >= 12), 32'd1);
         rise_cnt    = 0;
         cmd_bits    = 4'b0;
         frame_len   = 0;
         frame_abort = rst;
      end
      if (chip_select && !prev_cs) begin
         if (!frame_abort) begin
            check("frame_len", 32'(frame_len), 32'd72);
            check("sclk_rises", 32'(rise_cnt), 32'd18);
            had_frame = 1'b1;
         end
         hi_run = 0;
      end
      if (chip_select) hi_run++;
      else             frame_len++;
      if (!chip_select && sclk && !prev_sclk) begin
         if (rise_cnt < 4) cmd_bits = {cmd_bits[2:0], mosi};
         if (rise_cnt == 3) check("cmd_start_sgl", 32'(cmd_bits[3:2]), 32'd3);
         if (rise_cnt == 4 || rise_cnt == 5) check("lead_mosi", 32'(mosi), 32'd0);
         rise_cnt++;
      end
      // Data bit for period p sits on in_adc during its low half.
      if (!chip_select && rise_cnt >= 6 && rise_cnt < 18) begin
         cur_val = ch_val[cmd_bits[1:0]];
         in_adc  = cur_val[17 - rise_cnt];
      end else begin
         in_adc = 1'b0;
      end
      prev_cs    = chip_select;
      prev_sclk  = sclk;
      prev_mosi  = mosi;
      prev_valid = out_valid;
      prev_fire  = fire;
      prev_rst   = rst;
      prev_ch    = out_channel;
      prev_data  = datos_adc;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clk_adc);
      #1;
      rst    = 1'b1;
      enable = 1'b0;
      repeat (2) @(posedge clk_adc);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk_adc);
         k++;
      end
      check("drain_in_time", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic wait_rise(input int target, input int budget, output logic found);
      int k;
      k = 0;
      found = 1'b0;
      while (!found && k < budget) begin
         @(negedge clk_adc);
         if (!chip_select && rise_cnt == target) found = 1'b1;
         k++;
      end
   endtask

   typedef struct {
      logic [3:0] mask;
      int         n;
      logic [7:0] seq;
   } vec_t;

   vec_t vecs [6];
   logic found;

   initial begin
      vecs[0] = '{4'b0001, 3, {2'd0, 2'd0, 2'd0, 2'd0}};
      vecs[1] = '{4'b1010, 4, {2'd3, 2'd1, 2'd3, 2'd1}};
      vecs[2] = '{4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
      vecs[3] = '{4'b0110, 4, {2'd2, 2'd1, 2'd2, 2'd1}};
      vecs[4] = '{4'b1000, 2, {2'd0, 2'd0, 2'd3, 2'd3}};
      vecs[5] = '{4'b1001, 4, {2'd3, 2'd0, 2'd3, 2'd0}};
      ch_val[0] = 12'hA5C;
      ch_val[1] = 12'h111;
      ch_val[2] = 12'h6C9;
      ch_val[3] = 12'h333;

      // Reset state.
      repeat (3) @(posedge clk_adc);
      @(negedge clk_adc);
      check("rst_chip_select", 32'(chip_select), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_datos_adc", 32'(datos_adc), 32'd0);
      check("rst_out_channel", 32'(out_channel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);

      // Idle with enable=0, then with an empty mask.
      @(posedge clk_adc);
      #1;
      rst     = 1'b0;
      ch_mask = 4'b1111;
      repeat (30) @(negedge clk_adc);
      check("idle_dis_cs", 32'(chip_select), 32'd1);
      check("idle_dis_busy", 32'(busy), 32'd0);
      check("idle_dis_state", 32'(dbg_state), 32'd0);
      @(posedge clk_adc);
      #1;
      enable  = 1'b1;
      ch_mask = 4'b0000;
      repeat (30) @(negedge clk_adc);
      check("idle_nomask_cs", 32'(chip_select), 32'd1);
      check("idle_nomask_busy", 32'(busy), 32'd0);

      // Table of scan patterns, odd rows under random back-pressure.
      for (int v = 0; v < 6; v++) begin
         do_reset();
         ch_val[2]   = 12'($urandom_range(0, 4095));
         rand_ready  = v[0];
         ready_level = 1'b1;
         ch_mask     = vecs[v].mask;
         for (int k = 0; k < vecs[v].n; k++) begin
            logic [1:0] c;
            c = vecs[v].seq[2*k +: 2];
            exp_q.push_back({c, ch_val[c]});
         end
         enable = 1'b1;
         wait_drain(4000);
         enable     = 1'b0;
         rand_ready = 1'b0;
      end

      // Back-pressure: result held for 200 cycles with chip_select high.
      do_reset();
      ready_level = 1'b0;
      ch_mask     = 4'b0001;
      exp_q.push_back({2'd0, 12'hA5C});
      enable = 1'b1;
      found  = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk_adc);
         if (out_valid) found = 1'b1;
      end
      check("bp_valid_seen", 32'(found), 32'd1);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk_adc);
         check("bp_cs_high", 32'(chip_select), 32'd1);
      end
      @(posedge clk_adc);
      #1;
      ready_level = 1'b1;
      wait_drain(50);
      exp_q.push_back({2'd0, 12'hA5C});
      wait_drain(300);

      // Reset in the middle of the data phase of the ch1 frame.
      do_reset();
      ch_mask = 4'b0011;
      exp_q.push_back({2'd0, 12'hA5C});
      enable = 1'b1;
      wait_drain(300);
      wait_rise(11, 400, found);
      check("abort_reached_sample", 32'(found), 32'd1);
      @(posedge clk_adc);
      #1;
      rst = 1'b1;
      @(posedge clk_adc);
      #1;
      rst = 1'b0;
      @(negedge clk_adc);
      check("abort_cs_high", 32'(chip_select), 32'd1);
      check("abort_no_valid", 32'(out_valid), 32'd0);
      check("abort_sclk_low", 32'(sclk), 32'd0);
      exp_q.push_back({2'd0, 12'hA5C});
      wait_drain(300);

      // Mask change while a ch0 frame is running.
      do_reset();
      ch_val[2] = 12'($urandom_range(0, 4095));
      ch_mask   = 4'b0001;
      exp_q.push_back({2'd0, 12'hA5C});
      enable = 1'b1;
      wait_rise(8, 300, found);
      check("maskchg_mid_frame", 32'(found), 32'd1);
      @(posedge clk_adc);
      #1;
      ch_mask = 4'b0100;
      exp_q.push_back({2'd2, ch_val[2]});
      wait_drain(600);
      do_reset();

      check("protocol_violations", 32'(viol), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adc_scan_reader.md
ADC_SCAN_READER -- requirements
Module: adc_scan_reader

Interface
REQ-001 SHALL have parameter DATA_BITS, default 12: conversion result width.
REQ-002 SHALL have parameter NUM_CH, default 4: number of ADC input channels; CH_W = max(1, clog2(NUM_CH)).
REQ-003 SHALL have parameter LEAD_BITS, default 2: sclk periods after the command before the first data bit (sample + null bit).
REQ-004 SHALL have parameter SCLK_DIV, default 2 (>=1): clk_adc cycles per sclk half-period.
REQ-005 SHALL have parameter CS_IDLE, default 3 (>=1): minimum sclk periods chip_select stays high between frames.
REQ-006 Port list: clk_adc in 1 system clock. All logic SHALL be on its rising edge, with one clock and a synchronous active-high reset.
REQ-007 rst in 1 synchronous active-high reset.
REQ-008 enable in 1 scan enable.
REQ-009 ch_mask in NUM_CH channels included in the scan.
REQ-010 chip_select out 1 ADC CS, active low.
REQ-011 sclk out 1 ADC serial clock, idle low.
REQ-012 mosi out 1 command bit to the ADC.
REQ-013 in_adc in 1 serial data from the ADC.
REQ-014 out_valid out 1; out_ready in 1 result handshake.
REQ-015 out_channel out CH_W; datos_adc out DATA_BITS result channel and value.
REQ-016 busy out 1 high while chip_select is low or the CS_IDLE gap is running.

Function
REQ-017 States SHALL be IDLE, SELECT, CMD, SAMPLE, GAP and HOLD.
REQ-018 IDLE: when enable=1 and ch_mask!=0, select the next enabled channel at or after ptr in ascending order, wrapping NUM_CH-1->0, then go to SELECT. ptr is 0 after reset.
REQ-019 SELECT: drive chip_select low and mosi=1 (start bit) for one sclk half-period, then go to CMD.
REQ-020 Each sclk period SHALL be low for SCLK_DIV clk_adc cycles, then high for SCLK_DIV cycles.
REQ-021 mosi SHALL change only while sclk is low.
REQ-022 in_adc SHALL be sampled on the clk_adc edge that drives sclk high.
REQ-023 CMD SHALL shift 2+CH_W bits MSB-first: start=1, sgl=1, then the channel number.
REQ-024 LEAD_BITS periods SHALL follow the command, with in_adc ignored and mosi=0.
REQ-025 SAMPLE SHALL shift DATA_BITS bits MSB-first into a shift register.
REQ-026 On the final data sample: latch datos_adc and out_channel, set out_valid=1 on the next cycle, drive chip_select high and sclk low, set ptr=channel+1 mod NUM_CH, and go to GAP.
REQ-027 GAP SHALL hold chip_select high for CS_IDLE sclk periods, then go to HOLD.
REQ-028 HOLD: if out_valid=0, go to IDLE; otherwise wait. No new frame SHALL start while a result is unconsumed, so there is no overrun.
REQ-029 The output transfer SHALL occur when out_valid and out_ready are both high on a clock edge; out_valid clears on the next cycle.
REQ-030 datos_adc and out_channel SHALL be stable while out_valid=1.
REQ-031 Changes to ch_mask or enable SHALL take effect only at the IDLE channel selection; a frame in progress always completes.
REQ-032 With ch_mask=0 or enable=0 in IDLE, the block SHALL stay in IDLE with chip_select=1 and busy=0.
REQ-033 With a single enabled channel, that channel SHALL be converted repeatedly.

Reset
REQ-034 When rst=1 on a clock edge, the next state SHALL be: state=IDLE, chip_select=1, sclk=0, mosi=0, out_valid=0, datos_adc=0, out_channel=0, busy=0, ptr=0, bit counters=0.
REQ-035 A reset during CMD or SAMPLE SHALL abort the frame, raising chip_select on the next cycle with no out_valid pulse.
REQ-036 A pending unconsumed result SHALL be discarded on reset.

Verification
REQ-037 Defaults, ch_mask=4'b0001, enable=1, ADC model returns 12'hA5C, out_ready=1 -> mosi frame 1,1,00; out_valid=1 with datos_adc=12'hA5C and out_channel=0; the frame is 18 sclk periods (72 clk_adc cycles).
REQ-038 ch_mask=4'b1010 with per-channel values 1->12'h111 and 3->12'h333 -> results in order ch1, ch3, ch1, ch3 with matching data.
REQ-039 out_ready=0 for 200 cycles after the first result -> out_valid held, datos_adc stable, chip_select high throughout; the next frame starts only after out_ready=1.
REQ-040 rst pulsed mid-SAMPLE (bit 5) -> chip_select=1 on the next cycle, no out_valid; after release the scan restarts at ch0.
REQ-041 ch_mask changed from 4'b0001 to 4'b0100 mid-frame -> the current ch0 frame completes; the next frame selects ch2.
REQ-042 Gap check: chip_select high for >=CS_IDLE*2*SCLK_DIV = 12 cycles between frames; sclk low whenever chip_select=1.
